// File: rtl/trace_pkg.sv
// trace_pkg: constants and types shared by the trace frame transmitter.
//   - Frame header bytes, default frame sizes, index/address widths.
//   - state_t: framer FSM state encoding. The checksum state exists only when
//     TRACE_FRAME_CHECKSUM_EN is defined.
package trace_pkg;

    localparam int unsigned DefNumSamples = 1024;
    localparam int unsigned DefPtBytes    = 8;
    localparam int unsigned DefKeyBytes   = 10;

    // Sample memory address width; NUM_SAMPLES must not exceed 2**SmpAw.
    localparam int unsigned SmpAw = 10;
    // Byte index width within the header/pt/key/ct phases.
    localparam int unsigned IdxW  = 8;

    localparam logic [7:0] HdrByte0 = 8'h5A;
    localparam logic [7:0] HdrByte1 = 8'hA5;

    typedef enum logic [3:0] {
        StIdle,
        StHdr,
        StPt,
        StKey,
        StCt,
        StSmpRd,
        StSmpWait,
        StSend,
        StWaitDone,
`ifdef TRACE_FRAME_CHECKSUM_EN
        StCksum,
`endif
        StFin
    } state_t;

endpackage

// File: rtl/trace_frame_tx_if.sv
// trace_frame_tx_if: bundles the framer's sample-memory read port and its
// byte handshake with the UART transmitter.
//   smp_addr  : sample memory read address (framer -> memory)
//   smp_data  : read data, valid one cycle after smp_addr (memory -> framer)
//   tx_dv     : one-cycle byte strobe (framer -> UART)
//   tx_byte   : byte to transmit (framer -> UART)
//   tx_active : UART busy level (UART -> framer)
//   tx_done   : UART one-cycle byte-complete pulse (UART -> framer)
// Modports: master = framer side, slave = UART/memory side.
interface trace_frame_tx_if;
    import trace_pkg::*;

    logic [SmpAw-1:0] smp_addr;
    logic [7:0]       smp_data;
    logic             tx_dv;
    logic [7:0]       tx_byte;
    logic             tx_active;
    logic             tx_done;

    modport master (
        output smp_addr,
        input  smp_data,
        output tx_dv,
        output tx_byte,
        input  tx_active,
        input  tx_done
    );

    modport slave (
        input  smp_addr,
        output smp_data,
        input  tx_dv,
        input  tx_byte,
        output tx_active,
        output tx_done
    );

endinterface

// File: rtl/frame_byte_mux.sv
// frame_byte_mux: combinational selection of the current pt/key/ct byte.
//   phase    : current framer state (StPt/StKey/StCt select a field)
//   idx      : byte index within the field, 0 = most significant byte
//   pt,ct    : captured plaintext/ciphertext
//   key      : captured key
//   sel_byte : selected byte, 0 for any other phase or out-of-range index
module frame_byte_mux
    import trace_pkg::*;
#(
    parameter int unsigned PT_BYTES  = DefPtBytes,
    parameter int unsigned KEY_BYTES = DefKeyBytes
) (
    input  state_t                  phase,
    input  logic [IdxW-1:0]         idx,
    input  logic [PT_BYTES*8-1:0]   pt,
    input  logic [PT_BYTES*8-1:0]   ct,
    input  logic [KEY_BYTES*8-1:0]  key,
    output logic [7:0]              sel_byte
);

    logic [PT_BYTES*8-1:0]  pt_sh;
    logic [PT_BYTES*8-1:0]  ct_sh;
    logic [KEY_BYTES*8-1:0] key_sh;

    // Shift the wanted byte down to bit 0; index 0 is the MSB byte.
    always_comb begin
        pt_sh  = pt  >> (8 * (PT_BYTES  - 1 - 32'(idx)));
        ct_sh  = ct  >> (8 * (PT_BYTES  - 1 - 32'(idx)));
        key_sh = key >> (8 * (KEY_BYTES - 1 - 32'(idx)));
        sel_byte = 8'h00;
        case (phase)
            StPt:    sel_byte = pt_sh[7:0];
            StKey:   sel_byte = key_sh[7:0];
            StCt:    sel_byte = ct_sh[7:0];
            default: sel_byte = 8'h00;
        endcase
    end

endmodule

// File: rtl/trace_frame_tx.sv
// trace_frame_tx: sends one trace frame over a byte-wide UART on each start:
//   0x5A, 0xA5, pt (MSB first), key (MSB first), ct (MSB first),
//   samples 0..NUM_SAMPLES-1 from an external memory, optional checksum.
// Optional feature: define TRACE_FRAME_CHECKSUM_EN to append a byte equal to
// the mod-256 sum of every byte after the header.
// Ports:
//   clk, rst  : single clock, synchronous active-high reset
//   start     : one-cycle frame request, accepted only when idle
//   pt,ct,key : frame payload, captured when start is accepted
//   tx        : trace_frame_tx_if master (sample memory + UART handshake)
//   busy      : frame in progress
//   done      : one-cycle pulse when the frame is complete
module trace_frame_tx
    import trace_pkg::*;
#(
    parameter int unsigned NUM_SAMPLES = DefNumSamples,
    parameter int unsigned PT_BYTES    = DefPtBytes,
    parameter int unsigned KEY_BYTES   = DefKeyBytes
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [PT_BYTES*8-1:0]  pt,
    input  logic [PT_BYTES*8-1:0]  ct,
    input  logic [KEY_BYTES*8-1:0] key,
    trace_frame_tx_if.master       tx,
    output logic                   busy,
    output logic                   done
);

    state_t                 state;
    state_t                 phase;      // which section the byte in flight belongs to
    logic [IdxW-1:0]        idx;
    logic [PT_BYTES*8-1:0]  pt_reg;
    logic [PT_BYTES*8-1:0]  ct_reg;
    logic [KEY_BYTES*8-1:0] key_reg;
    logic                   dv_reg;
    logic [7:0]             byte_reg;
    logic [SmpAw-1:0]       addr_reg;   // doubles as the sample index
    logic [7:0]             mux_byte;
`ifdef TRACE_FRAME_CHECKSUM_EN
    logic [7:0]             cksum;
`endif

    assign tx.tx_dv    = dv_reg;
    assign tx.tx_byte  = byte_reg;
    assign tx.smp_addr = addr_reg;

    frame_byte_mux #(
        .PT_BYTES  (PT_BYTES),
        .KEY_BYTES (KEY_BYTES)
    ) u_byte_mux (
        .phase    (state),
        .idx      (idx),
        .pt       (pt_reg),
        .ct       (ct_reg),
        .key      (key_reg),
        .sel_byte (mux_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= StIdle;
            phase    <= StIdle;
            idx      <= '0;
            pt_reg   <= '0;
            ct_reg   <= '0;
            key_reg  <= '0;
            dv_reg   <= 1'b0;
            byte_reg <= 8'h00;
            addr_reg <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
`ifdef TRACE_FRAME_CHECKSUM_EN
            cksum    <= 8'h00;
`endif
        end else begin
            dv_reg <= 1'b0;
            done   <= 1'b0;
            case (state)
                StIdle: begin
                    if (start) begin
                        pt_reg   <= pt;
                        ct_reg   <= ct;
                        key_reg  <= key;
                        idx      <= '0;
                        addr_reg <= '0;
                        busy     <= 1'b1;
`ifdef TRACE_FRAME_CHECKSUM_EN
                        cksum    <= 8'h00;
`endif
                        state    <= StHdr;
                    end
                end
                StHdr: begin
                    byte_reg <= (idx == '0) ? HdrByte0 : HdrByte1;
                    phase    <= StHdr;
                    state    <= StSend;
                end
                StPt, StKey, StCt: begin
                    byte_reg <= mux_byte;
                    phase    <= state;
                    state    <= StSend;
                end
                StSmpRd: begin
                    phase <= StSmpRd;
                    state <= StSmpWait;
                end
                StSmpWait: begin
                    // Memory data for addr_reg is valid this cycle.
                    byte_reg <= tx.smp_data;
                    state    <= StSend;
                end
                StSend: begin
                    if (!tx.tx_active) begin
                        dv_reg <= 1'b1;
                        state  <= StWaitDone;
`ifdef TRACE_FRAME_CHECKSUM_EN
                        if (phase != StHdr && phase != StCksum) begin
                            cksum <= cksum + byte_reg;
                        end
`endif
                    end
                end
                StWaitDone: begin
                    if (tx.tx_done) begin
                        case (phase)
                            StHdr: begin
                                if (idx == IdxW'(1)) begin
                                    idx   <= '0;
                                    state <= StPt;
                                end else begin
                                    idx   <= idx + 1'b1;
                                    state <= StHdr;
                                end
                            end
                            StPt: begin
                                if (idx == IdxW'(PT_BYTES - 1)) begin
                                    idx   <= '0;
                                    state <= StKey;
                                end else begin
                                    idx   <= idx + 1'b1;
                                    state <= StPt;
                                end
                            end
                            StKey: begin
                                if (idx == IdxW'(KEY_BYTES - 1)) begin
                                    idx   <= '0;
                                    state <= StCt;
                                end else begin
                                    idx   <= idx + 1'b1;
                                    state <= StKey;
                                end
                            end
                            StCt: begin
                                if (idx == IdxW'(PT_BYTES - 1)) begin
                                    idx      <= '0;
                                    addr_reg <= '0;
                                    state    <= StSmpRd;
                                end else begin
                                    idx   <= idx + 1'b1;
                                    state <= StCt;
                                end
                            end
                            StSmpRd: begin
                                // Last sample: stop here, the address never wraps.
                                if (addr_reg == SmpAw'(NUM_SAMPLES - 1)) begin
`ifdef TRACE_FRAME_CHECKSUM_EN
                                    state <= StCksum;
`else
                                    done  <= 1'b1;
                                    state <= StFin;
`endif
                                end else begin
                                    addr_reg <= addr_reg + 1'b1;
                                    state    <= StSmpRd;
                                end
                            end
`ifdef TRACE_FRAME_CHECKSUM_EN
                            StCksum: begin
                                done  <= 1'b1;
                                state <= StFin;
                            end
`endif
                            default: state <= StIdle;
                        endcase
                    end
                end
`ifdef TRACE_FRAME_CHECKSUM_EN
                StCksum: begin
                    byte_reg <= cksum;
                    phase    <= StCksum;
                    state    <= StSend;
                end
`endif
                StFin: begin
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_trace_frame_tx.sv
module tb_trace_frame_tx;

    localparam int unsigned NS = 1024;
    localparam int unsigned PB = 8;
    localparam int unsigned KB = 10;
`ifdef TRACE_FRAME_CHECKSUM_EN
    localparam int unsigned CK = 1;
`else
    localparam int unsigned CK = 0;
`endif
    localparam int unsigned SMP_BASE  = 2 + 2 * PB + KB;
    localparam int unsigned FRAME_LEN = SMP_BASE + NS + CK;
    localparam int unsigned UART_LAT  = 10;
    localparam int          BUDGET    = 25000;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [63:0]   pt = '0;
    logic [63:0]   ct = '0;
    logic [79:0]   key = '0;
    logic          busy;
    logic          done;

    logic [7:0]    mem [NS];
    logic          uart_busy = 1'b0;
    logic          uart_done = 1'b0;
    logic          force_active = 1'b0;
    logic          spur_done = 1'b0;
    int            uart_cnt = 0;

    logic [7:0]    exp_q [$];
    int            checks = 0;
    int            failures = 0;
    int            rx_cnt = 0;
    int            done_cnt = 0;
    logic          prev_dv = 1'b0;
    logic          prev_done = 1'b0;

    trace_frame_tx_if tx_bus ();

    assign tx_bus.tx_active = uart_busy | force_active;
    assign tx_bus.tx_done   = uart_done | spur_done;

    always #5 clk = ~clk;

    trace_frame_tx #(
        .NUM_SAMPLES (NS),
        .PT_BYTES    (PB),
        .KEY_BYTES   (KB)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .pt    (pt),
        .ct    (ct),
        .key   (key),
        .tx    (tx_bus),
        .busy  (busy),
        .done  (done)
    );

    // Sample memory: registered read, data one cycle after the address.
    always @(posedge clk) tx_bus.smp_data <= mem[tx_bus.smp_addr];

    // UART model: busy after a strobe, done pulse 10 cycles after tx_dv.
    always @(posedge clk) begin
        uart_done <= 1'b0;
        if (uart_busy) begin
            if (uart_cnt == 0) begin
                uart_busy <= 1'b0;
                uart_done <= 1'b1;
            end else begin
                uart_cnt <= uart_cnt - 1;
            end
        end else if (tx_bus.tx_dv) begin
            uart_busy <= 1'b1;
            uart_cnt  <= UART_LAT - 2;
        end
    end

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endfunction

    // Reference model: the frame as a byte list built from the field rules.
    task automatic push_frame(input logic [63:0] p, input logic [79:0] k,
                              input logic [63:0] c);
        logic [7:0] f [$];
        int sum;
        f.push_back(8'h5A);
        f.push_back(8'hA5);
        for (int i = PB - 1; i >= 0; i--) f.push_back(p[i*8 +: 8]);
        for (int i = KB - 1; i >= 0; i--) f.push_back(k[i*8 +: 8]);
        for (int i = PB - 1; i >= 0; i--) f.push_back(c[i*8 +: 8]);
        for (int i = 0; i < NS; i++) f.push_back(mem[i]);
        if (CK != 0) begin
            sum = 0;
            for (int i = 2; i < f.size(); i++) sum += int'(f[i]);
            f.push_back(8'(sum));
        end
        foreach (f[i]) exp_q.push_back(f[i]);
    endtask

    // Monitor: pops the scoreboard on every strobe, tracks done pulses.
    always @(negedge clk) begin
        if (tx_bus.tx_dv) begin
            chk("strobe_while_active", 32'(tx_bus.tx_active), 0);
            chk("strobe_width", 32'(prev_dv), 0);
            chk("byte_expected", 32'(exp_q.size() != 0), 1);
            if (exp_q.size() != 0) begin
                chk($sformatf("byte%0d", rx_cnt), 32'(tx_bus.tx_byte),
                    32'(exp_q.pop_front()));
            end
            rx_cnt++;
        end
        if (done) begin
            done_cnt++;
            chk("done_width", 32'(prev_done), 0);
            chk("done_frame_len", rx_cnt, FRAME_LEN);
            chk("done_queue_empty", exp_q.size(), 0);
        end
        prev_dv   = tx_bus.tx_dv;
        prev_done = done;
    end

    task automatic randomize_stim();
        pt  = {$urandom(), $urandom()};
        ct  = {$urandom(), $urandom()};
        key = {$urandom(), $urandom(), 16'($urandom())};
        for (int i = 0; i < NS; i++) mem[i] = 8'($urandom());
    endtask

    task automatic begin_frame();
        push_frame(pt, key, ct);
        rx_cnt   = 0;
        done_cnt = 0;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        chk("busy_after_start", 32'(busy), 1);
    endtask

    task automatic wait_done();
        int c;
        c = 0;
        while (done_cnt == 0 && c < BUDGET) begin
            @(negedge clk);
            c++;
        end
        repeat (40) @(negedge clk);
        chk("single_done", done_cnt, 1);
        chk("frame_bytes", rx_cnt, FRAME_LEN);
        chk("idle_busy", 32'(busy), 0);
    endtask

    initial begin
        int c;
        int snap;
        bit mid_done;

        for (int i = 0; i < NS; i++) mem[i] = 8'(i);
        repeat (3) @(negedge clk);
        chk("rst_tx_dv", 32'(tx_bus.tx_dv), 0);
        chk("rst_tx_byte", 32'(tx_bus.tx_byte), 0);
        chk("rst_smp_addr", 32'(tx_bus.smp_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        rst = 1'b0;
        @(negedge clk);

        // Frame 1: reference values, held tx_active, spurious tx_done,
        // pt change after start, and two ignored start pulses.
        pt  = 64'h0123456789ABCDEF;
        key = 80'h3B6A8CF71E295D0B4F2E;
        ct  = 64'hFEDCBA9876543210;
        force_active = 1'b1;
        begin_frame();
        pt = '0;
        mid_done = 1'b0;
        c = 1;
        while (done_cnt == 0 && c < BUDGET) begin
            @(negedge clk);
            c++;
            start     = 1'b0;
            spur_done = 1'b0;
            if (c == 5) start = 1'b1;
            if (c == 20) spur_done = 1'b1;
            if (c == 50) begin
                chk("no_strobe_while_held", rx_cnt, 0);
                force_active = 1'b0;
            end
            if (!mid_done && rx_cnt >= int'(SMP_BASE) + 500) begin
                start    = 1'b1;
                mid_done = 1'b1;
            end
        end
        start     = 1'b0;
        spur_done = 1'b0;
        chk("mid_start_issued", 32'(mid_done), 1);
        wait_done();

        // Frame 2: random payload, reset while sample 300 is in flight.
        randomize_stim();
        begin_frame();
        c = 0;
        while (rx_cnt < int'(SMP_BASE) + 301 && c < BUDGET) begin
            @(negedge clk);
            c++;
        end
        chk("reached_sample300", 32'(rx_cnt >= int'(SMP_BASE) + 301), 1);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 32'(busy), 0);
        chk("abort_tx_dv", 32'(tx_bus.tx_dv), 0);
        chk("abort_done", 32'(done), 0);
        rst = 1'b0;
        exp_q.delete();
        snap = rx_cnt;
        repeat (40) @(negedge clk);
        chk("abort_no_more_bytes", rx_cnt, snap);
        chk("abort_no_done", done_cnt, 0);

        // Frame 3: random payload, full frame after the abort.
        randomize_stim();
        begin_frame();
        wait_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
